// File: rtl/inst_encoder.sv
// inst_encoder
// Sequential instruction encoder / program writer. Accepts decoded operation
// requests over a valid/ready handshake, packs each one into a 32-bit RV32
// R-type (0110011) or I-type (0010011) word and writes it to instruction
// memory at consecutive word addresses. On finish_i it writes a NOP
// terminator (addi x0,x0,0) and stops until reset.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   req_valid_i/ready_o request handshake
//   req_kind_i          0 = R-type, 1 = I-type
//   req_alu_i           0 and, 1 xor, 2 sll, 3 add/addi, 4 sub, 5 mul, 6 srai
//   req_rd_i/rs1_i/rs2_i register indices; req_imm_i I-type immediate
//   finish_i            level request for the terminator write
//   imem_we_o/addr_o/data_o  memory write port (byte address, word aligned)
//   count_o             words written, terminator included
//   full_o              only the terminator slot remains
//   err_o               sticky illegal-request flag
//   done_o              terminator written
module inst_encoder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_kind_i,
  input  logic [2:0]        req_alu_i,
  input  logic [4:0]        req_rd_i,
  input  logic [4:0]        req_rs1_i,
  input  logic [4:0]        req_rs2_i,
  input  logic [11:0]       req_imm_i,
  input  logic              finish_i,
  output logic              imem_we_o,
  output logic [ADDR_W+1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0]      OP_R      = 7'b0110011;
  localparam logic [6:0]      OP_I      = 7'b0010011;
  localparam logic [31:0]     NOP_WORD  = 32'h0000_0013;
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);

  state_t            state;
  logic [31:0]       word_q;
  logic              term_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_next;
  logic              full_q;
  logic              err_q;
  logic              done_q;

  logic              legal;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [11:0]       imm_enc;
  logic [31:0]       enc_word;
  logic              handshake;

  // Field selection and legality for the incoming request.
  always_comb begin
    legal   = 1'b0;
    funct3  = '0;
    funct7  = '0;
    imm_enc = req_imm_i;
    if (!req_kind_i) begin
      legal = 1'b1;
      unique case (req_alu_i)
        3'd0: funct3 = 3'b111;
        3'd1: funct3 = 3'b100;
        3'd2: funct3 = 3'b001;
        3'd3: funct3 = 3'b000;
        3'd4: funct7 = 7'b0100000;
        3'd5: funct7 = 7'b0000001;
        default: legal = 1'b0;
      endcase
    end else begin
      unique case (req_alu_i)
        3'd3: legal = 1'b1;
        3'd6: begin
          legal   = 1'b1;
          funct3  = 3'b101;
          // srai carries its arithmetic-shift marker in the upper immediate bits.
          imm_enc = {7'b0100000, req_imm_i[4:0]};
        end
        default: legal = 1'b0;
      endcase
    end
    if (!req_kind_i)
      enc_word = {funct7, req_rs2_i, req_rs1_i, funct3, req_rd_i, OP_R};
    else
      enc_word = {imm_enc, req_rs1_i, funct3, req_rd_i, OP_I};
  end

  assign req_ready_o = (state == IDLE) && !full_q && !finish_i;
  assign handshake   = req_valid_i && req_ready_o;
  assign count_next  = count_q + (ADDR_W+1)'(1);

  // While a write is pending count_q < DEPTH <= 2^ADDR_W, so the low
  // ADDR_W bits are the whole word address.
  assign imem_we_o   = (state == WRITE);
  assign imem_addr_o = {count_q[ADDR_W-1:0], 2'b00};
  assign imem_data_o = word_q;
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign err_o       = err_q;
  assign done_o      = done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      word_q  <= '0;
      term_q  <= 1'b0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // finish_i forces ready low, so it always beats a pending request.
          if (finish_i) begin
            word_q <= NOP_WORD;
            term_q <= 1'b1;
            state  <= WRITE;
          end else if (handshake) begin
            if (legal) begin
              word_q <= enc_word;
              term_q <= 1'b0;
              state  <= WRITE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          count_q <= count_next;
          full_q  <= (count_next == LAST_SLOT);
          if (term_q) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid = 1'b0;
  logic              ready;
  logic              kind = 1'b0;
  logic [2:0]        alu = '0;
  logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
  logic [11:0]       imm = '0;
  logic              finish = 1'b0;
  logic              we;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       data;
  logic [ADDR_W:0]   count;
  logic              full, err, done;

  int total = 0;
  int bad   = 0;

  inst_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid), .req_ready_o(ready),
    .req_kind_i(kind), .req_alu_i(alu),
    .req_rd_i(rd), .req_rs1_i(rs1), .req_rs2_i(rs2), .req_imm_i(imm),
    .finish_i(finish),
    .imem_we_o(we), .imem_addr_o(addr), .imem_data_o(data),
    .count_o(count), .full_o(full), .err_o(err), .done_o(done)
  );

  always #5 clk = ~clk;

  // Reference encoder: instruction word built from RV32 field positions.
  function automatic bit ref_legal(input logic k, input logic [2:0] a);
    if (k == 1'b0) return (a <= 3'd5);
    return (a == 3'd3) || (a == 3'd6);
  endfunction

  function automatic logic [31:0] ref_word(input logic k, input logic [2:0] a,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im);
    int unsigned f3_tab [8] = '{7, 4, 1, 0, 0, 0, 0, 0};
    int unsigned f7_tab [8] = '{0, 0, 0, 0, 32, 1, 0, 0};
    int unsigned w;
    if (k == 1'b0) begin
      w = f7_tab[a] * (1 << 25) + s2 * (1 << 20) + s1 * (1 << 15)
        + f3_tab[a] * (1 << 12) + d * (1 << 7) + 51;
    end else if (a == 3'd3) begin
      w = im * (1 << 20) + s1 * (1 << 15) + d * (1 << 7) + 19;
    end else begin
      w = (32 * 32 + (im % 32)) * (1 << 20) + s1 * (1 << 15) + 5 * (1 << 12) + d * (1 << 7) + 19;
    end
    return w;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic apply_reset();
    valid = 1'b0; finish = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_req(input logic k, input logic [2:0] a, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [11:0] im, output bit ok);
    kind = k; alu = a; rd = d; rs1 = s1; rs2 = s2; imm = im; valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({full, err, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {full, err, done}); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
  endtask

  task automatic test_add();
    bit ok;
    apply_reset();
    do_req(1'b0, 3'd3, 5'd3, 5'd1, 5'd2, 12'h000, ok);
    total++; if (!ok) begin bad++; $display("FAIL add_handshake got=timeout exp=handshake"); end
    total++; if (we !== 1'b1) begin bad++; $display("FAIL add_we got=%b exp=1", we); end
    total++; if (addr !== 10'h000) begin bad++; $display("FAIL add_addr got=%h exp=000", addr); end
    total++; if (data !== 32'h002081B3) begin bad++; $display("FAIL add_data got=%h exp=002081b3", data); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL add_ready_write got=%b exp=0", ready); end
    @(posedge clk); #1;
    total++; if (count !== 9'd1) begin bad++; $display("FAIL add_count got=%0d exp=1", count); end
    total++; if (we !== 1'b0) begin bad++; $display("FAIL add_we_after got=%b exp=0", we); end
  endtask

  task automatic test_addi_mul();
    bit ok;
    apply_reset();
    do_req(1'b1, 3'd3, 5'd5, 5'd0, 5'd31, 12'hFFF, ok);
    total++; if (!ok || we !== 1'b1 || addr !== 10'h000 || data !== 32'hFFF00293) begin
      bad++; $display("FAIL addi_write got=ok%b we%b a%h d%h exp=ok1 we1 a000 dfff00293", ok, we, addr, data); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL addi_ready got=%b exp=0", ready); end
    @(posedge clk); #1;
    do_req(1'b0, 3'd5, 5'd10, 5'd11, 5'd12, 12'hABC, ok);
    total++; if (!ok || we !== 1'b1 || addr !== 10'h004 || data !== 32'h02C58533) begin
      bad++; $display("FAIL mul_write got=ok%b we%b a%h d%h exp=ok1 we1 a004 d02c58533", ok, we, addr, data); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mul_ready got=%b exp=0", ready); end
    @(posedge clk); #1;
    total++; if (count !== 9'd2 || ready !== 1'b1) begin bad++; $display("FAIL mul_count got=%0d/%b exp=2/1", count, ready); end
  endtask

  task automatic test_srai();
    bit ok;
    apply_reset();
    do_req(1'b1, 3'd6, 5'd1, 5'd2, 5'd0, 12'hFE3, ok);
    total++; if (!ok || we !== 1'b1 || data !== 32'h40315093) begin
      bad++; $display("FAIL srai_data got=ok%b we%b d%h exp=ok1 we1 d40315093", ok, we, data); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    bit ok;
    apply_reset();
    do_req(1'b1, 3'd4, 5'd1, 5'd2, 5'd3, 12'h123, ok);
    total++; if (!ok || we !== 1'b0) begin bad++; $display("FAIL illegal_we got=ok%b we%b exp=ok1 we0", ok, we); end
    total++; if (err !== 1'b1 || count !== '0) begin bad++; $display("FAIL illegal_err got=%b/%0d exp=1/0", err, count); end
    do_req(1'b0, 3'd3, 5'd3, 5'd1, 5'd2, 12'h000, ok);
    total++; if (!ok || we !== 1'b1 || addr !== 10'h000 || data !== 32'h002081B3) begin
      bad++; $display("FAIL illegal_next got=ok%b we%b a%h d%h exp=ok1 we1 a000 d002081b3", ok, we, addr, data); end
    @(posedge clk); #1;
    total++; if (err !== 1'b1 || count !== 9'd1) begin bad++; $display("FAIL illegal_sticky got=%b/%0d exp=1/1", err, count); end
  endtask

  task automatic test_back_to_back_full();
    int n = 0;
    int writes = 0;
    apply_reset();
    kind = 1'b0; alu = 3'd1; rd = 5'd7; rs1 = 5'd8; rs2 = 5'd9; valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (we) begin
        total++;
        if (addr !== 10'(writes * 4) || data !== ref_word(1'b0, 3'd1, 5'd7, 5'd8, 5'd9, 12'h0)) begin
          bad++; $display("FAIL b2b_write got=a%h d%h exp=a%h", addr, data, 10'(writes * 4)); end
        writes++;
      end
      n++;
    end
    total++; if (writes != 3) begin bad++; $display("FAIL b2b_writes got=%0d exp=3", writes); end
    total++; if (full !== 1'b1 || ready !== 1'b0 || count !== 9'd3) begin
      bad++; $display("FAIL b2b_full got=f%b r%b c%0d exp=f1 r0 c3", full, ready, count); end
    finish = 1'b1;
    @(posedge clk); #1;
    total++; if (we !== 1'b1 || addr !== 10'h00C || data !== 32'h00000013) begin
      bad++; $display("FAIL term_write got=we%b a%h d%h exp=we1 a00c d00000013", we, addr, data); end
    @(posedge clk); #1;
    finish = 1'b0;
    total++; if (count !== 9'd4 || done !== 1'b1 || ready !== 1'b0) begin
      bad++; $display("FAIL term_done got=c%0d d%b r%b exp=c4 d1 r0", count, done, ready); end
    writes = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (we) writes++;
    end
    valid = 1'b0;
    total++; if (writes != 0 || count !== 9'd4 || done !== 1'b1) begin
      bad++; $display("FAIL done_hold got=w%0d c%0d d%b exp=w0 c4 d1", writes, count, done); end
  endtask

  task automatic test_finish_priority();
    apply_reset();
    kind = 1'b0; alu = 3'd0; rd = 5'd1; rs1 = 5'd1; rs2 = 5'd1;
    valid = 1'b1; finish = 1'b1;
    @(posedge clk); #1;
    total++; if (we !== 1'b1 || addr !== 10'h000 || data !== 32'h00000013) begin
      bad++; $display("FAIL prio_write got=we%b a%h d%h exp=we1 a000 d00000013", we, addr, data); end
    @(posedge clk); #1;
    valid = 1'b0; finish = 1'b0;
    total++; if (count !== 9'd1 || done !== 1'b1) begin bad++; $display("FAIL prio_done got=c%0d d%b exp=c1 d1", count, done); end
  endtask

  task automatic test_reset_during_write();
    bit ok;
    apply_reset();
    do_req(1'b0, 3'd2, 5'd4, 5'd5, 5'd6, 12'h0, ok);
    @(posedge clk); #1;
    do_req(1'b0, 3'd2, 5'd4, 5'd5, 5'd6, 12'h0, ok);
    total++; if (!ok || we !== 1'b1 || count !== 9'd1) begin bad++; $display("FAIL rstw_pre got=ok%b we%b c%0d exp=ok1 we1 c1", ok, we, count); end
    #2 rst = 1'b1;
    #1;
    total++; if (we !== 1'b0 || count !== '0 || {full, err, done} !== 3'b000) begin
      bad++; $display("FAIL rstw_async got=we%b c%0d f%b%b%b exp=we0 c0 000", we, count, full, err, done); end
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(1'b0, 3'd0, 5'd1, 5'd2, 5'd3, 12'h0, ok);
    total++; if (!ok || we !== 1'b1 || addr !== 10'h000) begin bad++; $display("FAIL rstw_after got=ok%b we%b a%h exp=ok1 we1 a000", ok, we, addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit ok;
    logic k; logic [2:0] a; logic [4:0] d, s1, s2; logic [11:0] im;
    int cnt;
    bit err_exp;
    for (int it = 0; it < 40; it++) begin
      apply_reset();
      cnt = 0; err_exp = 1'b0;
      for (int r = 0; r < 5 && cnt < DEPTH - 1; r++) begin
        k = 1'($urandom); a = 3'($urandom); d = 5'($urandom); s1 = 5'($urandom);
        s2 = 5'($urandom); im = 12'($urandom);
        do_req(k, a, d, s1, s2, im, ok);
        if (ref_legal(k, a)) begin
          total++; if (!ok || we !== 1'b1 || addr !== 10'(cnt * 4) || data !== ref_word(k, a, d, s1, s2, im)) begin
            bad++; $display("FAIL rand_write k%b a%0d got=we%b a%h d%h exp=a%h d%h", k, a, we, addr, data,
                            10'(cnt * 4), ref_word(k, a, d, s1, s2, im)); end
          @(posedge clk); #1;
          cnt++;
        end else begin
          err_exp = 1'b1;
          total++; if (!ok || we !== 1'b0) begin bad++; $display("FAIL rand_illegal k%b a%0d got=we%b exp=0", k, a, we); end
        end
        total++; if (count !== 9'(cnt) || err !== err_exp || full !== (cnt == DEPTH - 1)) begin
          bad++; $display("FAIL rand_state got=c%0d e%b f%b exp=c%0d e%b f%b", count, err, full, cnt, err_exp, cnt == DEPTH - 1); end
      end
      if ($urandom_range(1, 0) == 1) begin
        finish = 1'b1;
        @(posedge clk); #1;
        total++; if (we !== 1'b1 || addr !== 10'(cnt * 4) || data !== 32'h00000013) begin
          bad++; $display("FAIL rand_term got=we%b a%h d%h exp=we1 a%h d00000013", we, addr, data, 10'(cnt * 4)); end
        @(posedge clk); #1;
        finish = 1'b0;
        total++; if (done !== 1'b1 || count !== 9'(cnt + 1)) begin
          bad++; $display("FAIL rand_done got=d%b c%0d exp=d1 c%0d", done, count, cnt + 1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi_mul();
    test_srai();
    test_illegal();
    test_back_to_back_full();
    test_finish_priority();
    test_reset_during_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Sequential instruction encoder and program writer for the single-cycle RISC-V datapath. Accepts decoded operation requests over a valid/ready handshake, packs them into 32-bit R-type (0110011) or I-type (0010011) words, and writes them into instruction memory at consecutive word addresses. On request it appends a NOP terminator. It is the encoding counterpart of the opcode-to-control decode path and is used to load programs and self-test sequences.

## Interface
- ADDR_W, 8: word-address width; byte address is ADDR_W+2 bits.
- DEPTH, 256: memory depth in words; must be ≥2 and ≤2^ADDR_W.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_kind_i  in  1  0=R-type, 1=I-type.
- req_alu_i  in  3  operation code: 0 and, 1 xor, 2 sll, 3 add/addi, 4 sub, 5 mul, 6 srai, 7 reserved.
- req_rd_i, req_rs1_i, req_rs2_i  in  5 each  register indices.
- req_imm_i  in  12  I-type immediate.
- finish_i  in  1  level; request terminator write.
- imem_we_o  out  1  write strobe, one cycle per word.
- imem_addr_o  out  ADDR_W+2  byte address, always word-aligned.
- imem_data_o  out  32  encoded word.
- count_o  out  ADDR_W+1  words written, including terminator.
- full_o  out  1  count_o == DEPTH-1; last slot reserved for terminator.
- err_o  out  1  sticky illegal-request flag.
- done_o  out  1  terminator written.

## Operation
- States: IDLE, WRITE, DONE.
- req_ready_o = (state==IDLE) & ~full_o & ~finish_i. A handshake is valid & ready at a rising edge.
- Legal requests are R-type with alu 0–5, or I-type with alu 3 or 6.
- On a legal handshake, register the encoded word and go to WRITE.
- An illegal handshake is consumed but not written. It sets err_o, and state and count are unchanged.
- R-type encoding: {funct7, rs2, rs1, funct3, rd, 0110011}. funct3/funct7 per alu code:
  - and: 111/0000000
  - xor: 100/0000000
  - sll: 001/0000000
  - add: 000/0000000
  - sub: 000/0100000
  - mul: 000/0000001
- I-type encoding: {imm, rs1, funct3, rd, 0010011}.
  - addi: funct3 000, imm = req_imm_i.
  - srai: funct3 101, imm = {0100000, req_imm_i[4:0]}; req_imm_i[11:5] is ignored.
  - req_rs2_i is ignored for I-type.
- WRITE lasts one cycle:
  - imem_we_o=1, imem_addr_o = count_o×4, imem_data_o = registered word.
  - At the next edge count_o increments and state returns to IDLE.
- In IDLE with finish_i=1:
  - Go to WRITE with word 0x00000013 (addi x0,x0,0) marked as terminator.
  - After that write, go to DONE instead of IDLE.
  - finish_i is allowed while full_o=1.
- finish_i is ignored in WRITE and DONE; it is sampled again on return to IDLE.
- In DONE: req_ready_o=0 and done_o=1 until reset. No further writes.
- Simultaneous req_valid_i and finish_i: finish wins, because ready is low and no handshake occurs.
- imem_addr_o and imem_data_o are don't-care when imem_we_o=0; drive them with the registered values.

## Timing
- Reset values: all outputs 0, state IDLE. req_ready_o goes high in the first cycle after reset release (combinational from state).
- Reset during WRITE aborts the write: imem_we_o drops asynchronously and count_o clears.
- Latency: handshake at edge N → imem_we_o high in cycle N..N+1 → count_o updates at edge N+1.
- Throughput: one word per 2 cycles. req_ready_o is low during WRITE.
- err_o sets at the edge of the illegal handshake.
- full_o and done_o are registered and update at the same edge as count_o.

## Test plan
- add x3,x1,x2 (kind 0, alu 3) → one write, addr 0x000, data 0x002081B3; count_o=1.
- addi x5,x0,imm 0xFFF, then mul x10,x11,x12 → 0xFFF00293 at 0x000, 0x02C58533 at 0x004; ready low for one cycle after each handshake.
- srai x1,x2 with imm 0xFE3 → 0x40315093 (upper imm bits overridden).
- Illegal request: kind 1, alu 4 → no imem_we_o, err_o=1 and stays set, count_o unchanged; a following legal add writes at addr 0x000.
- DEPTH=4, back-to-back valid requests:
  - After 3 writes, full_o=1 and ready=0.
  - finish_i → 0x00000013 at addr 0x00C, count_o=4, done_o=1.
  - Further req_valid_i is ignored.
- rst_i asserted during WRITE → imem_we_o=0 immediately and all outputs 0; after release, first write goes to addr 0.
